// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the operand stage, the register file and the ALU.
// Contents:
//   XLEN       - default operand / register width
//   REG_ADDR_W - default register index width (2**REG_ADDR_W registers)
//   ALU_CTRL_W - default ALU control width
//   A0_IDX     - architectural index of register a0 (x10)
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 1;
  localparam int A0_IDX     = 10;
endpackage : cpu_pkg

// File: rtl/reg_file.sv
// Register file: 2**ADDR_WIDTH x DATA_WIDTH storage.
// Two combinational read ports, one synchronous write port, and a live tap of a0.
// Register 0 is hard-wired to zero: writes to it are dropped.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (clears every register)
//   i_we/i_waddr/i_wdata - write port, takes effect at the rising edge
//   i_raddr1/i_raddr2   - read indices
//   o_rdata1/o_rdata2   - read data (stored contents, no bypass)
//   o_a0                - stored contents of register A0_IDX
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2,
  output logic [DATA_WIDTH-1:0] o_a0
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NREGS];

  // Register 0 gets a flop that is never written, so it stays at its reset value of zero.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[gi] <= '0;
      end else if (gi != 0 && i_we && i_waddr == ADDR_WIDTH'(gi)) begin
        r_regs[gi] <= i_wdata;
      end
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];
  assign o_a0     = r_regs[A0_IDX];
endmodule : reg_file

// File: rtl/operand_stage.sv
// Operand fetch stage: reads two source registers (with writeback bypass), selects
// the immediate when requested, and holds the operand set in an output register
// with a valid/ready handshake towards the ALU.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   in_valid / in_ready       - upstream issue handshake
//   rs1, rs2                  - source register indices
//   ImmOp, ALUsrc, ALUctrl_in - immediate, op2 select (1 = ImmOp), ALU operation
//   wb_en, wb_addr, wb_data   - writeback port into the register file
//   out_valid / out_ready     - downstream handshake
//   ALUctrl, ALUop1, ALUop2   - registered operand set
//   a0                        - stored contents of x10 (not bypassed)
module operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int CTRLSIG    = ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  ALUsrc,
  input  logic [CTRLSIG-1:0]    ALUctrl_in,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRLSIG-1:0]    ALUctrl,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [DATA_WIDTH-1:0] a0
);
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;
  logic [DATA_WIDTH-1:0] w_op1, w_op2_reg;
  logic                  w_wb_hit, w_accept;

  logic                  r_out_valid;
  logic [CTRLSIG-1:0]    r_ctrl;
  logic [DATA_WIDTH-1:0] r_op1, r_op2;

  // x0 writes are dropped here as well, so the register file never sees them.
  assign w_wb_hit = wb_en && (wb_addr != '0);

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_wb_hit),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (rs1),
    .i_raddr2 (rs2),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .o_a0     (a0)
  );

  // Same-cycle writeback is forwarded so an issue never sees a stale value.
  assign w_op1     = (w_wb_hit && wb_addr == rs1) ? wb_data : w_rd1;
  assign w_op2_reg = (w_wb_hit && wb_addr == rs2) ? wb_data : w_rd2;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_ctrl      <= ALUctrl_in;
        r_op1       <= w_op1;
        r_op2       <= ALUsrc ? ImmOp : w_op2_reg;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign ALUctrl   = r_ctrl;
  assign ALUop1    = r_op1;
  assign ALUop2    = r_op2;
endmodule : operand_stage

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: the stimulus process pushes the expected
// operand set when an issue is accepted; the monitor pops and compares on every
// completed output handshake.
module tb_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] ImmOp = '0;
  logic        ALUsrc = 1'b0;
  logic [0:0]  ALUctrl_in = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [0:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2, a0;

  typedef struct {
    logic [0:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .ImmOp(ImmOp), .ALUsrc(ALUsrc), .ALUctrl_in(ALUctrl_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic src,
                       input logic [31:0] imm, input logic [0:0] ctrl);
    in_valid = 1'b1; rs1 = a; rs2 = b; ALUsrc = src; ImmOp = imm; ALUctrl_in = ctrl;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic push(input logic [0:0] c, input logic [31:0] o1, input logic [31:0] o2);
    exp_t e;
    e.ctrl = c; e.op1 = o1; e.op2 = o2;
    exp_q.push_back(e);
  endtask

  // Monitor: a transfer is sampled on the falling edge and completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got op1=0x%08h op2=0x%08h, want none", ALUop1, ALUop2);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out.op1", ALUop1, e.op1);
          check("out.op2", ALUop2, e.op2);
          check("out.ctrl", {31'd0, ALUctrl}, {31'd0, e.ctrl});
        end
      end
    end
  end

  initial begin
    #2;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.a0", a0, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // write-read
    wb(5'd5, 32'h0000_00AA); tick(); idle();
    issue(5'd5, 5'd0, 1'b0, 32'h0, 1'b0); push(1'b0, 32'hAA, 32'h0); tick(); idle();
    check("wr.out_valid", {31'd0, out_valid}, 32'd1);

    // x0: dropped write, also not bypassed in the same cycle
    wb(5'd0, 32'hFFFF_FFFF); tick(); idle();
    wb(5'd0, 32'hFFFF_FFFF); issue(5'd0, 5'd0, 1'b0, 32'h0, 1'b0); push(1'b0, 32'h0, 32'h0);
    tick(); idle();
    check("x0.a0", a0, 32'd0);

    // bypass on both ports
    wb(5'd3, 32'h0000_1234); issue(5'd3, 5'd3, 1'b0, 32'h0, 1'b0);
    push(1'b0, 32'h1234, 32'h1234); tick(); idle();

    // immediate select
    issue(5'd5, 5'd3, 1'b1, 32'h7, 1'b1); push(1'b1, 32'hAA, 32'h7); tick(); idle();

    // a0 follows x10 one cycle later, never bypassed
    wb(5'd10, 32'h55); #1;
    check("a0.nobypass", a0, 32'd0);
    tick(); idle();
    check("a0.updated", a0, 32'h55);

    // stall: hold for 3 cycles while rs1 is rewritten
    out_ready = 1'b0;
    issue(5'd10, 5'd5, 1'b0, 32'h0, 1'b0); push(1'b0, 32'h55, 32'hAA); tick(); idle();
    for (int k = 0; k < 3; k++) begin
      wb(5'd10, 32'h99); in_valid = 1'b1; tick();
      check("stall.in_ready", {31'd0, in_ready}, 32'd0);
      check("stall.op1", ALUop1, 32'h55);
      check("stall.op2", ALUop2, 32'hAA);
    end
    idle();
    // release: drain and new accept in the same cycle, no bubble
    out_ready = 1'b1;
    issue(5'd10, 5'd0, 1'b0, 32'h0, 1'b1); push(1'b1, 32'h99, 32'h0); #1;
    check("release.in_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    check("release.out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("drain.out_valid", {31'd0, out_valid}, 32'd0);

    // reset mid-stall: the held set is dropped, never transferred
    out_ready = 1'b0;
    issue(5'd10, 5'd5, 1'b0, 32'h0, 1'b0); tick(); idle();
    check("pre_rst.out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0; #1;
    check("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst.a0", a0, 32'd0);
    check("mid_rst.op1", ALUop1, 32'd0);
    wb(5'd7, 32'hDEAD_BEEF); tick(); tick(); idle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(5'd10, 5'd7, 1'b0, 32'h0, 1'b0); push(1'b0, 32'h0, 32'h0); tick(); idle();
    issue(5'd5, 5'd3, 1'b0, 32'h0, 1'b0); push(1'b0, 32'h0, 32'h0); tick(); idle();
    check("post_rst.a0", a0, 32'd0);
    tick(); tick();

    check("scoreboard.empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule : tb_operand_stage

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand/register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the register index width (2**ADDR_WIDTH registers).
REQ-003 SHALL have parameter CTRLSIG, default 1, the ALU control width passed through.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid (input, 1, issue request) and in_ready (output, 1, stage can accept).
REQ-007 SHALL have ports rs1 and rs2, input, ADDR_WIDTH each, source register indices.
REQ-008 SHALL have ports ImmOp (input, DATA_WIDTH, immediate), ALUsrc (input, 1, 1 selects ImmOp as op2), ALUctrl_in (input, CTRLSIG, ALU operation).
REQ-009 SHALL have ports wb_en (input, 1), wb_addr (input, ADDR_WIDTH) and wb_data (input, DATA_WIDTH), the writeback port.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake to the ALU.
REQ-011 SHALL have ports ALUctrl (output, CTRLSIG), ALUop1 (output, DATA_WIDTH) and ALUop2 (output, DATA_WIDTH), registered ALU operands.
REQ-012 SHALL have port a0, output, DATA_WIDTH, live contents of register 10.

Function
REQ-013 SHALL hold a 2**ADDR_WIDTH x DATA_WIDTH register file with two combinational read ports and one synchronous write port.
REQ-014 SHALL write wb_data to wb_addr at the clock edge when wb_en=1 and wb_addr!=0.
REQ-015 SHALL ignore writes to register 0; reads of register 0 return 0 always.
REQ-016 SHALL bypass: when wb_en=1, wb_addr!=0 and wb_addr equals rs1 (or rs2) in the same cycle, the read value is wb_data.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL capture on in_valid && in_ready: ALUop1 <= read(rs1); ALUop2 <= ALUsrc ? ImmOp : read(rs2); ALUctrl <= ALUctrl_in; out_valid <= 1.
REQ-019 SHALL clear out_valid when out_valid && out_ready && !(in_valid && in_ready).
REQ-020 SHALL hold ALUctrl, ALUop1 and ALUop2 stable while out_valid=1 and out_ready=0, even if the source registers are rewritten.
REQ-021 SHALL give one cycle latency from accepted issue to out_valid=1; full throughput of one per cycle when out_ready=1.
REQ-022 SHALL allow simultaneous accept and drain in one cycle, replacing the output contents with no bubble.
REQ-023 SHALL leave the operand registers unchanged when no capture occurs; these are don't-care while out_valid=0.
REQ-024 SHALL update a0 one cycle after a write to register 10; a0 shall not be bypassed.

Reset
REQ-025 SHALL on rst_n=0 immediately clear all registers, out_valid, ALUctrl, ALUop1, ALUop2 and a0 to 0.
REQ-026 SHALL drop any in-flight operand set on reset mid-operation; no output handshake completes while rst_n=0.
REQ-027 SHALL ignore wb_en while rst_n=0 and resume normal operation on the first rising edge after deassertion.

Structure
REQ-028 SHALL take DATA_WIDTH/ADDR_WIDTH defaults and the A0_IDX=10 constant from shared package cpu_pkg, also used by ALU.
REQ-029 SHALL instantiate one sub-module, reg_file (storage, x0 rule, write port, a0 tap); bypass and handshake logic sit in operand_stage.

Verification
REQ-030 SHALL cover write-read: wb x5=0x0000_00AA, then issue rs1=5, rs2=0, ALUsrc=0 -> next cycle out_valid=1, ALUop1=0xAA, ALUop2=0.
REQ-031 SHALL cover x0: wb x0=0xFFFF_FFFF, issue rs1=0 -> ALUop1=0; a0 unaffected.
REQ-032 SHALL cover bypass: same cycle wb x3=0x1234 and issue rs1=3, rs2=3 -> ALUop1=ALUop2=0x1234.
REQ-033 SHALL cover stall: out_ready=0 with out_valid=1 -> in_ready=0, outputs hold 3 cycles despite wb to rs1; out_ready=1 -> new issue accepted same cycle.
REQ-034 SHALL cover immediate: ALUsrc=1, ImmOp=0x7, ALUctrl_in=1 -> ALUop2=0x7, ALUctrl=1.
REQ-035 SHALL cover reset mid-stall: out_valid=1 and x10=0x55, pulse rst_n low -> out_valid=0, a0=0, all reads 0.
